// File: rtl/pattern_gen.sv
// Video test-pattern generator: re-times sync/DE by one dot clock and paints bars, ramp, checkerboard or border.
// Optional PATGEN_SCROLL_EN adds a frame counter that scrolls the ramp and checkerboard horizontally.
module pattern_gen (
    input  logic       DCLK,
    input  logic       DRST,
    input  logic [1:0] RESOL,
    input  logic [1:0] PATSEL,
    input  logic       HSYNC_X_IN,
    input  logic       VSYNC_X_IN,
    input  logic       PREDE_IN,
    output logic       DSP_HSYNC_X,
    output logic       DSP_VSYNC_X,
    output logic       DSP_DE,
    output logic [7:0] DSP_R,
    output logic [7:0] DSP_G,
    output logic [7:0] DSP_B
);

    localparam int unsigned CW   = 11;
    localparam int unsigned BW   = 8;
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic {S_WAIT, S_RUN} state_t;

    state_t        state;
    logic          vs_prev;
    logic          de_prev;
    logic [CW-1:0] xcnt;
    logic [CW-1:0] ycnt;
    logic [CW-1:0] last_line;
    logic [1:0]    patsel_sh;
    logic [1:0]    resol_sh;
    logic [BW-1:0] bar_pos;
    logic [2:0]    bar_idx;

    logic          vs_fall;
    logic          de_fall;
    logic [CW-1:0] active_w;
    logic [BW-1:0] bar_w;
    logic [7:0]    pat_x;
    logic [23:0]   pix_rgb;

    assign vs_fall = vs_prev & ~VSYNC_X_IN;
    assign de_fall = de_prev & ~PREDE_IN;

`ifdef PATGEN_SCROLL_EN
    logic [7:0] fcnt;
    // Only the low byte of (XCNT+FCNT) mod 2048 is ever looked at
    assign pat_x = xcnt[7:0] + fcnt;
`else
    assign pat_x = xcnt[7:0];
`endif

    // Active width and bar width for the frame's shadowed resolution
    always_comb begin
        active_w = CW'(640);
        bar_w    = BW'(80);
        case (resol_sh)
            2'b00: begin active_w = CW'(640);  bar_w = BW'(80);  end
            2'b01: begin active_w = CW'(800);  bar_w = BW'(100); end
            2'b10: begin active_w = CW'(1024); bar_w = BW'(128); end
            2'b11: begin active_w = CW'(1280); bar_w = BW'(160); end
            default: ;
        endcase
    end

    // Pixel colour for the current XCNT/YCNT
    always_comb begin
        pix_rgb = 24'h000000;
        case (patsel_sh)
            2'b00: pix_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            2'b01: pix_rgb = {pat_x, pat_x, pat_x};
            2'b10: pix_rgb = (pat_x[5] ^ ycnt[5]) ? 24'h000000 : 24'hFFFFFF;
            2'b11: begin
                if (ycnt == '0 || ycnt == last_line || xcnt == '0 || xcnt == active_w - CW'(1))
                    pix_rgb = 24'hFFFFFF;
                else
                    pix_rgb = 24'h0000FF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            state       <= S_WAIT;
            vs_prev     <= 1'b0;
            de_prev     <= 1'b0;
            xcnt        <= '0;
            ycnt        <= '0;
            last_line   <= '0;
            patsel_sh   <= 2'b00;
            resol_sh    <= 2'b00;
            bar_pos     <= '0;
            bar_idx     <= '0;
            DSP_HSYNC_X <= 1'b1;
            DSP_VSYNC_X <= 1'b1;
            DSP_DE      <= 1'b0;
            DSP_R       <= '0;
            DSP_G       <= '0;
            DSP_B       <= '0;
`ifdef PATGEN_SCROLL_EN
            fcnt        <= '0;
`endif
        end else begin
            DSP_HSYNC_X <= HSYNC_X_IN;
            DSP_VSYNC_X <= VSYNC_X_IN;
            vs_prev     <= VSYNC_X_IN;
            de_prev     <= PREDE_IN;

            case (state)
                S_WAIT:  if (vs_fall) state <= S_RUN;
                S_RUN:   state <= S_RUN;
                default: state <= S_WAIT;
            endcase

            // Output blank until the first frame boundary has been seen
            if (PREDE_IN && state == S_RUN) begin
                DSP_DE <= 1'b1;
                {DSP_R, DSP_G, DSP_B} <= pix_rgb;
            end else begin
                DSP_DE <= 1'b0;
                {DSP_R, DSP_G, DSP_B} <= 24'h000000;
            end

            if (!PREDE_IN)
                xcnt <= '0;
            else if (xcnt != CMAX)
                xcnt <= xcnt + CW'(1);

            // Frame clear takes priority over a coincident line increment
            if (vs_fall)
                ycnt <= '0;
            else if (de_fall && ycnt != CMAX)
                ycnt <= ycnt + CW'(1);

            if (vs_fall) begin
                patsel_sh <= PATSEL;
                resol_sh  <= RESOL;
                last_line <= (state == S_RUN && ycnt != '0) ? ycnt - CW'(1) : '0;
`ifdef PATGEN_SCROLL_EN
                if (state == S_RUN)
                    fcnt <= fcnt + 8'd1;
`endif
            end

            if (!PREDE_IN) begin
                bar_pos <= '0;
                bar_idx <= '0;
            end else if (bar_pos == bar_w - BW'(1)) begin
                bar_pos <= '0;
                if (bar_idx != 3'd7)
                    bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_pos <= bar_pos + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: frame-level vector table plus hand sequences for reset, timing and edge cases.
module tb_pattern_gen;

    localparam logic [23:0] WH = 24'hFFFFFF, YE = 24'hFFFF00, CY = 24'h00FFFF, GR = 24'h00FF00;
    localparam logic [23:0] MA = 24'hFF00FF, RD = 24'hFF0000, BL = 24'h0000FF, BK = 24'h000000;

    logic       clk;
    logic       rst;
    logic [1:0] resol;
    logic [1:0] patsel;
    logic       hs;
    logic       vs;
    logic       pde;
    logic       dsp_hs;
    logic       dsp_vs;
    logic       dsp_de;
    logic [7:0] dsp_r;
    logic [7:0] dsp_g;
    logic [7:0] dsp_b;

    pattern_gen dut (
        .DCLK(clk), .DRST(rst), .RESOL(resol), .PATSEL(patsel),
        .HSYNC_X_IN(hs), .VSYNC_X_IN(vs), .PREDE_IN(pde),
        .DSP_HSYNC_X(dsp_hs), .DSP_VSYNC_X(dsp_vs), .DSP_DE(dsp_de),
        .DSP_R(dsp_r), .DSP_G(dsp_g), .DSP_B(dsp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          frame;
        int          line;
        int          px;
        logic [23:0] rgb;
    } vec_t;

    vec_t        vecs[$];
    logic [23:0] line_rgb[0:1279];
    logic        line_de[0:1279];
    int          de_seen;
    int          errors;
    int          checks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scroll offset seen by ramp/checker in a given frame id (ids >= 10 follow a reset)
    function automatic int foff(input int f);
`ifdef PATGEN_SCROLL_EN
        return (f >= 10) ? f - 10 : f;
`else
        return 0;
`endif
    endfunction

    function automatic logic [23:0] ramp_exp(input int px, input int f);
        logic [7:0] v;
        v = 8'((px + foff(f)) & 255);
        return {v, v, v};
    endfunction

    function automatic logic [23:0] checker_exp(input int x, input int y, input int f);
        int xs;
        xs = (x + foff(f)) & 2047;
        return ((((xs >> 5) ^ (y >> 5)) & 1) != 0) ? BK : WH;
    endfunction

    task automatic add(input int f, input int l, input int p, input logic [23:0] c);
        vec_t v;
        v.frame = f; v.line = l; v.px = p; v.rgb = c;
        vecs.push_back(v);
    endtask

    // One line: hsync pulse, blank, npx active cycles; optionally drop VSYNC together with the DE fall
    task automatic run_line(input int npx, input bit vs_at_end);
        hs = 1'b0; step(); step();
        hs = 1'b1; step();
        for (int i = 0; i < npx; i++) begin
            pde = 1'b1;
            step();
            line_rgb[i] = {dsp_r, dsp_g, dsp_b};
            line_de[i]  = dsp_de;
            if (dsp_de) de_seen++;
        end
        pde = 1'b0;
        if (vs_at_end) vs = 1'b0;
        step(); step();
    endtask

    task automatic run_vsync();
        vs = 1'b0; repeat (3) step();
        vs = 1'b1; repeat (2) step();
    endtask

    task automatic check_vecs(input int f, input int l);
        foreach (vecs[k]) begin
            if (vecs[k].frame == f && vecs[k].line == l)
                chk($sformatf("f%0d_y%0d_x%0d", f, l, vecs[k].px), 32'(line_rgb[vecs[k].px]), 32'(vecs[k].rgb));
        end
    endtask

    task automatic run_frame(input int f, input int nlines, input int npx, input int mid_patsel);
        run_vsync();
        for (int l = 0; l < nlines; l++) begin
            run_line(npx, 1'b0);
            check_vecs(f, l);
            if (l == 0 && mid_patsel >= 0) patsel = 2'(mid_patsel);
        end
    endtask

    initial begin
        errors = 0; checks = 0; de_seen = 0;

        // Frame 0: 640 bars
        add(0, 0, 0, WH); add(0, 0, 79, WH); add(0, 0, 80, YE);
        add(0, 1, 559, BL); add(0, 1, 560, BK); add(0, 1, 639, BK);
        // Frame 1: 800 bars, PATSEL switched to checkerboard after line 0
        add(1, 0, 99, WH);  add(1, 0, 100, YE); add(1, 0, 200, CY); add(1, 0, 300, GR);
        add(1, 0, 400, MA); add(1, 0, 500, RD); add(1, 0, 600, BL); add(1, 0, 700, BK);
        add(1, 0, 799, BK); add(1, 1, 100, YE); add(1, 1, 650, BL);
        // Frame 2: checkerboard
        add(2, 0, 0, checker_exp(0, 0, 2));    add(2, 0, 32, checker_exp(32, 0, 2));
        add(2, 32, 32, checker_exp(32, 32, 2)); add(2, 32, 0, checker_exp(0, 32, 2));
        add(2, 31, 31, checker_exp(31, 31, 2)); add(2, 5, 63, checker_exp(63, 5, 2));
        // Frame 3: grey ramp
        add(3, 0, 0, ramp_exp(0, 3));     add(3, 0, 5, ramp_exp(5, 3));
        add(3, 0, 255, ramp_exp(255, 3)); add(3, 0, 256, ramp_exp(256, 3));
        add(3, 0, 299, ramp_exp(299, 3));
        // Frames 4/5: border; frame 3 had one line, frame 4 has six
        add(4, 0, 300, WH); add(4, 1, 0, WH); add(4, 1, 1, BL); add(4, 1, 638, BL);
        add(4, 1, 639, WH); add(4, 5, 100, BL);
        add(5, 5, 100, WH); add(5, 4, 100, BL); add(5, 3, 639, WH);
        // Frame after mid-frame reset: ramp
        add(10, 0, 0, ramp_exp(0, 10)); add(10, 0, 10, ramp_exp(10, 10)); add(10, 0, 63, ramp_exp(63, 10));

        // Reset with every input at its non-idle value
        rst = 1'b1; hs = 1'b0; vs = 1'b0; pde = 1'b1; patsel = 2'b11; resol = 2'b11;
        repeat (4) step();
        chk("rst_hsync", 32'(dsp_hs), 32'd1);
        chk("rst_vsync", 32'(dsp_vs), 32'd1);
        chk("rst_de", 32'(dsp_de), 32'd0);
        chk("rst_rgb", {8'd0, dsp_r, dsp_g, dsp_b}, 32'd0);
        rst = 1'b0; hs = 1'b1; vs = 1'b1; pde = 1'b0; patsel = 2'b00; resol = 2'b00;
        step(); step();

        // Lines before the first VSYNC fall stay blank
        de_seen = 0;
        for (int l = 0; l < 4; l++) run_line(640, 1'b0);
        chk("wait_no_de", 32'(de_seen), 32'd0);
        chk("wait_rgb", 32'(line_rgb[10]), 32'd0);

        run_frame(0, 2, 640, -1);
        chk("f0_de_px0", 32'(line_de[0]), 32'd1);
        resol = 2'b01;
        run_frame(1, 2, 800, 2);
        run_frame(2, 40, 64, -1);
        patsel = 2'b01;
        run_frame(3, 1, 300, -1);
        patsel = 2'b11; resol = 2'b00;
        run_frame(4, 6, 640, -1);
        run_frame(5, 6, 640, -1);

        // VSYNC fall coincident with DE fall: the clear must win
        run_line(640, 1'b1);
        step();
        vs = 1'b1; step(); step();
        run_line(640, 1'b0);
        chk("vs_de_same_y0", 32'(line_rgb[100]), 32'(WH));
        run_line(640, 1'b0);
        chk("vs_de_same_y1", 32'(line_rgb[100]), 32'(BL));

        // Sync and DE are the inputs delayed by exactly one clock
        begin
            logic [2:0] pat[0:5];
            pat[0] = 3'b111; pat[1] = 3'b010; pat[2] = 3'b101;
            pat[3] = 3'b110; pat[4] = 3'b001; pat[5] = 3'b111;
            for (int i = 0; i < 6; i++) begin
                {hs, vs, pde} = pat[i];
                step();
                chk($sformatf("dly_hs_%0d", i), 32'(dsp_hs), 32'(pat[i][2]));
                chk($sformatf("dly_vs_%0d", i), 32'(dsp_vs), 32'(pat[i][1]));
                chk($sformatf("dly_de_%0d", i), 32'(dsp_de), 32'(pat[i][0]));
            end
            hs = 1'b1; vs = 1'b1; pde = 1'b0;
            step(); step();
        end

        // DRST pulse at line 200, pixel 300
        patsel = 2'b00; resol = 2'b00;
        run_vsync();
        for (int l = 0; l < 200; l++) run_line(302, 1'b0);
        hs = 1'b0; step(); step(); hs = 1'b1; step();
        for (int i = 0; i < 300; i++) begin pde = 1'b1; step(); end
        chk("pre_rst_px299", {8'd0, dsp_r, dsp_g, dsp_b}, 32'(GR));
        rst = 1'b1; hs = 1'b0;
        step();
        chk("midrst_de", 32'(dsp_de), 32'd0);
        chk("midrst_rgb", {8'd0, dsp_r, dsp_g, dsp_b}, 32'd0);
        chk("midrst_hsync", 32'(dsp_hs), 32'd1);
        chk("midrst_vsync", 32'(dsp_vs), 32'd1);
        rst = 1'b0; hs = 1'b1;
        de_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dsp_de) de_seen++;
        end
        pde = 1'b0; step(); step();
        for (int l = 0; l < 2; l++) run_line(302, 1'b0);
        chk("postrst_blank", 32'(de_seen), 32'd0);
        patsel = 2'b01;
        run_frame(10, 1, 64, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 The block SHALL have the port DCLK, input, 1 bit: dot clock; every flop is clocked on its rising edge.
REQ-002 The block SHALL have the port DRST, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port RESOL, input, 2 bits: resolution select, mapped as 00=640, 01=800, 10=1024, 11=1280 active pixels per line.
REQ-004 The block SHALL have the port PATSEL, input, 2 bits: pattern select, mapped as 00 colour bars, 01 grey ramp, 10 checkerboard, 11 bordered field.
REQ-005 The block SHALL have the port HSYNC_X_IN, input, 1 bit: horizontal sync from the sync generator, active-low.
REQ-006 The block SHALL have the port VSYNC_X_IN, input, 1 bit: vertical sync from the sync generator, active-low.
REQ-007 The block SHALL have the port PREDE_IN, input, 1 bit: data-enable one cycle early from the sync generator.
REQ-008 The block SHALL have the port DSP_HSYNC_X, output, 1 bit: registered horizontal sync.
REQ-009 The block SHALL have the port DSP_VSYNC_X, output, 1 bit: registered vertical sync.
REQ-010 The block SHALL have the port DSP_DE, output, 1 bit: pixel valid.
REQ-011 The block SHALL have the ports DSP_R, DSP_G and DSP_B, outputs, 8 bits each: pixel colour.

Function
REQ-012 DSP_HSYNC_X, DSP_VSYNC_X and DSP_DE SHALL be HSYNC_X_IN, VSYNC_X_IN and PREDE_IN delayed by exactly one DCLK, so sync stays aligned with data.
REQ-013 The state machine SHALL have two states: S_WAIT and S_RUN.
- S_WAIT -> S_RUN on the first VSYNC_X_IN falling edge (1 -> 0).
- S_RUN has no exit except DRST.
REQ-014 In S_WAIT, DSP_DE SHALL be 0 and RGB SHALL be 0; sync SHALL still pass through per REQ-012.
REQ-015 XCNT (11 bits) SHALL count PREDE_IN-high cycles starting from 0, and SHALL clear to 0 when PREDE_IN is low.
REQ-016 XCNT SHALL saturate at 2047.
REQ-017 YCNT (11 bits) SHALL increment on each PREDE_IN falling edge, SHALL clear on the VSYNC_X_IN falling edge, and SHALL saturate at 2047.
REQ-018 When the VSYNC fall and the PREDE fall occur in the same cycle, the clear SHALL win.
REQ-019 PATSEL and RESOL SHALL be sampled into shadow registers only on the VSYNC_X_IN falling edge; a mid-frame change SHALL take effect next frame.
REQ-020 Colour bars SHALL show 8 bars in the order white, yellow, cyan, green, magenta, red, blue, black, with components 0 or 255.
REQ-021 Bar width SHALL be active width/8 (80/100/128/160 px), produced by a bar-position counter and a 3-bit bar index, both reset at line start; the index SHALL hold at 7 past the last bar.
REQ-022 The grey ramp SHALL output R=G=B=XCNT[7:0], wrapping every 256 px.
REQ-023 The checkerboard SHALL use 32x32 cells: white when XCNT[5]^YCNT[5]=0, else black.
REQ-024 The bordered field SHALL be white on line 0, the last counted line of the previous frame, column 0 and column width-1, and blue (0,0,255) elsewhere.
REQ-025 The last-line value SHALL be the YCNT maximum captured at the VSYNC fall; in the first frame it SHALL be 0.
REQ-026 RGB SHALL be registered, valid in the same cycle as DSP_DE=1, and forced to 0 when DSP_DE=0.

Reset
REQ-027 While DRST=1, the block SHALL drive DSP_HSYNC_X=1, DSP_VSYNC_X=1, DSP_DE=0 and RGB=0.
REQ-028 While DRST=1, the block SHALL clear every counter, set the state to S_WAIT and set the shadow registers to 00.
REQ-029 DRST asserted mid-frame SHALL take effect on the next edge; after release, output SHALL stay blank until the next VSYNC fall.

Configuration
REQ-030 With PATGEN_SCROLL_EN defined, an 8-bit frame counter SHALL increment on each VSYNC fall in S_RUN and wrap 255 -> 0.
REQ-031 With PATGEN_SCROLL_EN defined, the ramp and checkerboard SHALL use (XCNT+FCNT) mod 2048 in place of XCNT; bars and border SHALL be unaffected.
REQ-032 Without PATGEN_SCROLL_EN, there SHALL be no frame counter and the patterns SHALL be static.

Verification
REQ-033 The bench SHALL check: DRST high 4 cycles, then a 640-wide frame -> no DSP_DE before the first VSYNC fall; first active pixel of the next frame is RGB=(255,255,255).
REQ-034 The bench SHALL check: PATSEL=00, RESOL=01 -> colour changes at pixels 100, 200 ... 700; pixel 799 is (0,0,0).
REQ-035 The bench SHALL check: PATSEL 00 -> 10 switched mid-frame -> bars complete that frame; checkerboard in the next frame with pixel (32,0) black and pixel (32,32) white.
REQ-036 The bench SHALL check: PREDE_IN toggled -> DSP_DE is PREDE_IN delayed by exactly 1 cycle, and the sync outputs are delayed by 1 cycle.
REQ-037 The bench SHALL check: DRST pulsed at line 200 pixel 300 -> outputs idle the next cycle; blank until VSYNC; the next frame is correct.
REQ-038 With PATGEN_SCROLL_EN, the bench SHALL check: grey ramp -> in frame 3, pixel 0 is R=G=B=3.
